// File: rtl/alu_pkg.sv
// Shared ALU definitions: submodule select, per-unit opcodes and flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        ARITHMETIC = 2'd0,
        LOGIC      = 2'd1,
        LSHIFT     = 2'd2,
        RSHIFT     = 2'd3
    } alu_unit_t;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ADC = 2'b10;
    localparam logic [1:0] SBC = 2'b11;

    localparam logic [1:0] NOT = 2'b00;
    localparam logic [1:0] AND = 2'b01;
    localparam logic [1:0] OR  = 2'b10;
    localparam logic [1:0] XOR = 2'b11;

    // Bit positions inside the {CF,OF,ZF} flag vector
    localparam int unsigned CF = 2;
    localparam int unsigned OF = 1;
    localparam int unsigned ZF = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] win_s;
    logic [PW-1:0] cand_s;
    logic          found_s;

    // Scan from ptr_r+1 upward with wrap; the first valid requester wins
    always_comb begin
        grant   = '0;
        win_s   = ptr_r;
        cand_s  = '0;
        found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s = PW'((int'(ptr_r) + k) % N);
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                win_s         = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves only when the grant is actually consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PW'(N - 1);
        end else if (advance && found_s) begin
            ptr_r <= win_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues requests from N_REQ requesters onto a shared ALU and registers the
// response plus the architectural CF/OF/ZF flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int N_REQ     = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   in_req_valid,
    input  logic [N_REQ-1:0][1:0]              in_req_unit,
    input  logic [N_REQ-1:0][1:0]              in_req_op,
    input  logic [N_REQ-1:0][BIT_WIDTH-1:0]    in_req_a,
    input  logic [N_REQ-1:0][BIT_WIDTH-1:0]    in_req_b,
    output logic [N_REQ-1:0]                   out_req_ready,
    output logic                               out_rsp_valid,
    output logic [$clog2(N_REQ)-1:0]           out_rsp_id,
    output logic [BIT_WIDTH-1:0]               out_rsp_r,
    output logic [2:0]                         out_rsp_flags,
    input  logic                               in_rsp_ready,
    input  logic                               in_flag_clr,
    output logic [3:0][1:0]                    out_alu_op,
    output logic [3:0][BIT_WIDTH-1:0]          out_alu_a,
    output logic [3:0][BIT_WIDTH-1:0]          out_alu_b,
    input  logic [3:0][BIT_WIDTH-1:0]          in_alu_r,
    output logic                               out_alu_cf_in,
    input  logic                               in_alu_cf,
    input  logic                               in_alu_of,
    input  logic                               in_alu_zf
);

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     grant_s;
    logic                 any_grant_s;
    logic                 can_accept_s;
    logic                 accept_s;
    logic [ID_W-1:0]      win_idx_s;
    alu_unit_t            win_unit_s;
    logic [2:0]           flag_next_s;

    logic                 rsp_valid_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic [BIT_WIDTH-1:0] rsp_r_r;
    logic [2:0]           rsp_flags_r;
    logic [2:0]           flag_r;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_req_valid),
        .advance (can_accept_s),
        .grant   (grant_s)
    );

    assign any_grant_s   = |grant_s;
    assign can_accept_s  = !rsp_valid_r || in_rsp_ready;
    assign accept_s      = any_grant_s && can_accept_s;
    assign out_req_ready = grant_s & {N_REQ{can_accept_s}};

    // Convert the one-hot grant into the winner index
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                win_idx_s = ID_W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    assign win_unit_s = alu_unit_t'(in_req_unit[win_idx_s]);

    // Only the addressed submodule sees the payload; the rest stay at zero
    always_comb begin
        out_alu_op = '0;
        out_alu_a  = '0;
        out_alu_b  = '0;
        if (any_grant_s) begin
            out_alu_op[win_unit_s] = in_req_op[win_idx_s];
            out_alu_a[win_unit_s]  = in_req_a[win_idx_s];
            out_alu_b[win_unit_s]  = in_req_b[win_idx_s];
        end else begin
            out_alu_op = '0;
        end
    end

    // An accepted arithmetic op overrides a same-edge flag clear
    always_comb begin
        if (accept_s && (win_unit_s == ARITHMETIC)) begin
            flag_next_s = {in_alu_cf, in_alu_of, in_alu_zf};
        end else if (in_flag_clr) begin
            flag_next_s = 3'b000;
        end else begin
            flag_next_s = flag_r;
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_r <= 3'b000;
        end else begin
            flag_r <= flag_next_s;
        end
    end

    // One-deep response register: load on accept, drain on consumer ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_r_r     <= '0;
            rsp_flags_r <= 3'b000;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= win_idx_s;
            rsp_r_r     <= in_alu_r[win_unit_s];
            rsp_flags_r <= flag_next_s;
        end else if (in_rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign out_rsp_valid = rsp_valid_r;
    assign out_rsp_id    = rsp_id_r;
    assign out_rsp_r     = rsp_r_r;
    assign out_rsp_flags = rsp_flags_r;
    assign out_alu_cf_in = flag_r[CF];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with a behavioural ALU and
// a transaction-level reference model of arbitration, response and flags.
module tb_alu_issue_ctrl;

    localparam int W     = 4;
    localparam int N     = 2;
    localparam int IDW   = $clog2(N);
    localparam int FULL  = 1 << W;
    localparam int HALF  = 1 << (W - 1);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          in_req_valid;
    logic [N-1:0][1:0]     in_req_unit;
    logic [N-1:0][1:0]     in_req_op;
    logic [N-1:0][W-1:0]   in_req_a;
    logic [N-1:0][W-1:0]   in_req_b;
    logic [N-1:0]          out_req_ready;
    logic                  out_rsp_valid;
    logic [IDW-1:0]        out_rsp_id;
    logic [W-1:0]          out_rsp_r;
    logic [2:0]            out_rsp_flags;
    logic                  in_rsp_ready;
    logic                  in_flag_clr;
    logic [3:0][1:0]       out_alu_op;
    logic [3:0][W-1:0]     out_alu_a;
    logic [3:0][W-1:0]     out_alu_b;
    logic [3:0][W-1:0]     in_alu_r;
    logic                  out_alu_cf_in;
    logic                  in_alu_cf;
    logic                  in_alu_of;
    logic                  in_alu_zf;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl #(.BIT_WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req_valid(in_req_valid), .in_req_unit(in_req_unit), .in_req_op(in_req_op),
        .in_req_a(in_req_a), .in_req_b(in_req_b), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_id(out_rsp_id), .out_rsp_r(out_rsp_r),
        .out_rsp_flags(out_rsp_flags), .in_rsp_ready(in_rsp_ready), .in_flag_clr(in_flag_clr),
        .out_alu_op(out_alu_op), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
        .in_alu_r(in_alu_r), .out_alu_cf_in(out_alu_cf_in),
        .in_alu_cf(in_alu_cf), .in_alu_of(in_alu_of), .in_alu_zf(in_alu_zf)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {CF,OF,ZF,R} from plain integer arithmetic
    function automatic logic [W+2:0] alu_calc(input logic [1:0] unit, input logic [1:0] op,
                                              input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin);
        int ua, ub, sa, sb, c, u, s;
        logic [W-1:0] r;
        logic cf, of;
        ua = int'(a); ub = int'(b); c = int'(cin);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        cf = 1'b0; of = 1'b0; r = '0; u = 0; s = 0;
        case (unit)
            2'd0: begin
                case (op)
                    2'd0:    begin u = ua + ub;     s = sa + sb;     end
                    2'd1:    begin u = ua - ub;     s = sa - sb;     end
                    2'd2:    begin u = ua + ub + c; s = sa + sb + c; end
                    default: begin u = ua - ub - c; s = sa - sb - c; end
                endcase
                r  = W'(u);
                cf = (u < 0) || (u >= FULL);
                of = (s >= HALF) || (s < -HALF);
            end
            2'd1: begin
                case (op)
                    2'd0:    r = ~a;
                    2'd1:    r = a & b;
                    2'd2:    r = a | b;
                    default: r = a ^ b;
                endcase
            end
            2'd2:    r = W'(ua << ub);
            default: r = W'(ua >> ub);
        endcase
        return {cf, of, (r == '0), r};
    endfunction

    logic [W+2:0] ar0, ar1, ar2, ar3;
    assign ar0 = alu_calc(2'd0, out_alu_op[0], out_alu_a[0], out_alu_b[0], out_alu_cf_in);
    assign ar1 = alu_calc(2'd1, out_alu_op[1], out_alu_a[1], out_alu_b[1], out_alu_cf_in);
    assign ar2 = alu_calc(2'd2, out_alu_op[2], out_alu_a[2], out_alu_b[2], out_alu_cf_in);
    assign ar3 = alu_calc(2'd3, out_alu_op[3], out_alu_a[3], out_alu_b[3], out_alu_cf_in);
    assign in_alu_r  = {ar3[W-1:0], ar2[W-1:0], ar1[W-1:0], ar0[W-1:0]};
    assign in_alu_cf = ar0[W+2];
    assign in_alu_of = ar0[W+1];
    assign in_alu_zf = ar0[W];

    // Reference model state
    int           m_ptr;
    logic [2:0]   m_flags;
    logic         m_rv;
    int           m_id;
    logic [W-1:0] m_r;
    logic [2:0]   m_rf;
    logic [N-1:0] m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = N - 1; m_flags = 3'b000; m_rv = 1'b0; m_id = 0;
        m_r = '0; m_rf = 3'b000; m_acc = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] unit,
                           input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_req_valid[i] = v; in_req_unit[i] = unit; in_req_op[i] = op;
        in_req_a[i] = a; in_req_b[i] = b;
    endtask

    // One clock: inputs set at the preceding negedge; compare combinational
    // outputs, advance the model, then compare registered outputs.
    task automatic cycle();
        int g, j;
        logic can;
        logic [IDW-1:0] gi;
        logic [N-1:0] er;
        logic [3:0][1:0] eop;
        logic [3:0][W-1:0] ea, eb;
        logic [W+2:0] res;
        #1;
        can = !m_rv || in_rsp_ready;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && in_req_valid[j]) g = j;
        end
        gi = (g >= 0) ? g[IDW-1:0] : '0;
        er = '0; eop = '0; ea = '0; eb = '0;
        if (g >= 0) begin
            eop[in_req_unit[gi]] = in_req_op[gi];
            ea[in_req_unit[gi]]  = in_req_a[gi];
            eb[in_req_unit[gi]]  = in_req_b[gi];
            if (can) er[gi] = 1'b1;
        end
        chk("req_ready", out_req_ready, er);
        chk("alu_op", out_alu_op, eop);
        chk("alu_a", out_alu_a, ea);
        chk("alu_b", out_alu_b, eb);
        chk("alu_cf_in", out_alu_cf_in, m_flags[2]);
        m_acc = er;
        if (g >= 0 && can) begin
            res = alu_calc(in_req_unit[gi], in_req_op[gi], in_req_a[gi], in_req_b[gi], m_flags[2]);
            if (in_req_unit[gi] == 2'd0) m_flags = res[W+2:W];
            else if (in_flag_clr) m_flags = 3'b000;
            m_rv = 1'b1; m_id = g; m_r = res[W-1:0]; m_rf = m_flags; m_ptr = g;
        end else begin
            if (in_flag_clr) m_flags = 3'b000;
            if (in_rsp_ready) m_rv = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", out_rsp_valid, m_rv);
        if (m_rv) begin
            chk("rsp_id", out_rsp_id, m_id);
            chk("rsp_r", out_rsp_r, m_r);
            chk("rsp_flags", out_rsp_flags, m_rf);
        end
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", out_rsp_valid, 1'b0);
        chk("rst_cf_in", out_alu_cf_in, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_req_valid = '0; in_req_unit = '0; in_req_op = '0; in_req_a = '0; in_req_b = '0;
        in_rsp_ready = 1'b1; in_flag_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_valid", out_rsp_valid, 1'b0);
        chk("reset_id", out_rsp_id, 0);
        chk("reset_r", out_rsp_r, 0);
        chk("reset_flags", out_rsp_flags, 3'b000);
        chk("reset_cf_in", out_alu_cf_in, 1'b0);
        @(negedge clk);

        // ADD then chained ADC
        set_req(0, 1'b1, 2'd0, 2'b00, 4'd9, 4'd8);
        cycle();
        chk("add_r", out_rsp_r, 4'd1);
        chk("add_id", out_rsp_id, 0);
        chk("add_flags", out_rsp_flags, 3'b110);
        set_req(0, 1'b1, 2'd0, 2'b10, 4'd0, 4'd0);
        cycle();
        chk("adc_r", out_rsp_r, 4'd1);
        chk("adc_flags", out_rsp_flags, 3'b000);
        set_req(0, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0);
        cycle();

        // Alternating grants straight after reset
        mid_reset();
        set_req(0, 1'b1, 2'd1, 2'b10, 4'd3, 4'd4);
        set_req(1, 1'b1, 2'd1, 2'b10, 4'd5, 4'd8);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_order", out_rsp_id, i % 2);
        end

        // SUB, then LOGIC keeps flags
        set_req(0, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0);
        set_req(1, 1'b1, 2'd0, 2'b01, 4'd5, 4'd3);
        cycle();
        chk("sub_r", out_rsp_r, 4'd2);
        chk("sub_flags", out_rsp_flags, 3'b000);
        set_req(1, 1'b1, 2'd1, 2'b01, 4'hC, 4'hA);
        cycle();
        chk("and_r", out_rsp_r, 4'h8);
        chk("and_flags", out_rsp_flags, 3'b000);
        set_req(1, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0);
        set_req(0, 1'b1, 2'd0, 2'b00, 4'd9, 4'd8);
        cycle();
        set_req(0, 1'b1, 2'd1, 2'b01, 4'hC, 4'hA);
        cycle();
        chk("and_keeps_flags", out_rsp_flags, 3'b110);

        // Back-pressure for three cycles with both requesters waiting
        in_rsp_ready = 1'b0;
        set_req(0, 1'b1, 2'd1, 2'b11, 4'h1, 4'h2);
        set_req(1, 1'b1, 2'd1, 2'b11, 4'h4, 4'h8);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", out_req_ready, 2'b00);
            cycle();
            chk("stall_hold_r", out_rsp_r, 4'h8);
        end
        in_rsp_ready = 1'b1;
        cycle();
        chk("release_id", out_rsp_id, 1);
        chk("release_r", out_rsp_r, 4'hC);

        // Flag clear with a LOGIC accept on the same edge
        set_req(1, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0);
        set_req(0, 1'b1, 2'd1, 2'b11, 4'h3, 4'h3);
        in_flag_clr = 1'b1;
        cycle();
        chk("clr_flags", out_rsp_flags, 3'b000);
        in_flag_clr = 1'b0;

        // Random traffic honouring the hold-until-ready rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_req_valid[i] && !m_acc[i])) begin
                    set_req(i, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3)), W'($urandom_range(0, FULL - 1)),
                            W'($urandom_range(0, FULL - 1)));
                end
            end
            in_rsp_ready = ($urandom_range(0, 3) != 0);
            in_flag_clr  = ($urandom_range(0, 15) == 0);
            if (c == 200) mid_reset();
            cycle();
        end

        // Reset mid-stream, then requester 0 wins first
        in_flag_clr = 1'b0;
        in_rsp_ready = 1'b1;
        mid_reset();
        set_req(0, 1'b1, 2'd1, 2'b10, 4'h1, 4'h2);
        set_req(1, 1'b1, 2'd1, 2'b10, 4'h4, 4'h8);
        cycle();
        chk("post_reset_first", out_rsp_id, 0);
        chk("post_reset_r", out_rsp_r, 4'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Shares the single ALU among N_REQ requesters using round-robin arbitration.
- Routes each granted request to the addressed ALU submodule: ARITHMETIC, LOGIC, LSHIFT or RSHIFT.
- Captures the ALU result into a one-deep response register and holds the architectural CF/OF/ZF flag register.
- Feeds CF back into the ALU carry input, so multi-word ADC/SBC chains run back-to-back without bubbles.

Parameters:
- BIT_WIDTH, 4, operand/result width; must equal the ALU bit_width.
- N_REQ, 2, number of requesters (2..8).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- IN_REQ_VALID  in  [N_REQ]  request valid per requester.
- IN_REQ_UNIT  in  [N_REQ][1:0]  submodule select (alu_unit_t).
- IN_REQ_OP  in  [N_REQ][1:0]  submodule opcode.
- IN_REQ_A  in  [N_REQ][BIT_WIDTH]  operand A.
- IN_REQ_B  in  [N_REQ][BIT_WIDTH]  operand B.
- OUT_REQ_READY  out  [N_REQ]  accept strobe (one-hot or zero).
- OUT_RSP_VALID  out  1  response valid.
- OUT_RSP_ID  out  clog2(N_REQ)  index of the originating requester.
- OUT_RSP_R  out  BIT_WIDTH  result.
- OUT_RSP_FLAGS  out  3  {CF,OF,ZF} snapshot after this op.
- IN_RSP_READY  in  1  consumer accepts the response.
- IN_FLAG_CLR  in  1  synchronous clear of the flag register.
- OUT_ALU_OP  out  [4][1:0]  per-submodule opcode to the ALU.
- OUT_ALU_A  out  [4][BIT_WIDTH]  per-submodule operand A to the ALU.
- OUT_ALU_B  out  [4][BIT_WIDTH]  per-submodule operand B to the ALU.
- IN_ALU_R  in  [4][BIT_WIDTH]  per-submodule results from the ALU.
- OUT_ALU_CF_IN  out  1  carry into the ALU; always equals the flag register CF.
- IN_ALU_CF, IN_ALU_OF, IN_ALU_ZF  in  1 each  ALU arithmetic flags.

Behaviour:
- Reset (async, RST_N=0) clears all registers:
  - OUT_RSP_VALID=0, OUT_RSP_ID=0, OUT_RSP_R=0, OUT_RSP_FLAGS=0, flag register=0.
  - Round-robin pointer=N_REQ-1, so requester 0 has highest priority first.
  - Reset mid-transaction drops any pending response; requesters must re-present requests.
- Acceptance condition: can_accept = !OUT_RSP_VALID | IN_RSP_READY.
- Arbitration:
  - grant = first valid requester searching from pointer+1, wrapping at N_REQ-1 to 0.
  - OUT_REQ_READY[i] = grant[i] & can_accept; this is combinational from the inputs.
  - The pointer updates to the granted index only on an actual accept; it holds on stall or idle.
- Requester rule: a requester holds VALID and its payload stable until its READY is asserted.
- ALU drive:
  - For the submodule named by the winning UNIT: OUT_ALU_OP/A/B = the winner's payload.
  - The other three submodules are driven all-zero.
  - All submodules are driven zero when there is no grant.
- Latency: a request accepted on edge N gives a response valid from cycle N+1.
  - Sustained throughput is 1 op/clock while IN_RSP_READY=1.
- Response register: loads on accept. Otherwise OUT_RSP_VALID clears when IN_RSP_READY=1 and holds when IN_RSP_READY=0.
- Flag register:
  - Updates at the accept edge, and only when UNIT=ARITHMETIC: CF/OF/ZF are taken from the ALU.
  - LOGIC and shift ops leave the flags unchanged.
  - OUT_RSP_FLAGS = the flag register value after this op.
  - Because OUT_ALU_CF_IN is the registered CF, a chained ADC accepted on the next cycle sees the new carry with no hazard.
- IN_FLAG_CLR:
  - Clears the flags at the edge.
  - If an arithmetic op is accepted on the same edge, the op's flags win, and that op used the pre-clear CF.
- Back-pressure: with OUT_RSP_VALID=1 and IN_RSP_READY=0, all READY signals are 0, the ALU inputs are still driven, and no state changes.

Decomposition:
- Shared package alu_pkg:
  - alu_unit_t enum (ARITHMETIC=0, LOGIC=1, LSHIFT=2, RSHIFT=3).
  - Arithmetic opcode constants: ADD=00, SUB=01, ADC=10, SBC=11.
  - Logic opcode constants: NOT=00, AND=01, OR=10, XOR=11.
  - Flag index constants: CF=2, OF=1, ZF=0.
- Sub-module rr_arbiter: parameter N, inputs req/advance, output one-hot grant; owns the pointer.

Test Plan (BIT_WIDTH=4, N_REQ=2, ALU instantiated):
- Req0 ARITH ADD A=9 B=8, IN_RSP_READY=1 -> next cycle R=1, ID=0, FLAGS={CF=1,OF=1,ZF=0}.
- Following cycle req0 ADC A=0 B=0 -> R=1, FLAGS={CF=0,OF=0,ZF=0}; proves back-to-back carry chaining.
- Req0 and req1 both valid continuously after reset -> grants 0,1,0,1 on consecutive cycles; RSP_ID follows the same order.
- Req1 ARITH SUB A=5 B=3 -> R=2, CF=0. Then req1 LOGIC AND A=0xC B=0xA -> R=0x8 with FLAGS unchanged from the SUB.
- Response pending with IN_RSP_READY=0 for 3 cycles, both requesters valid -> READY=0 throughout and the response is held; on release one accept occurs and the pointer is unchanged while stalled.
- IN_FLAG_CLR with a LOGIC accept on the same edge -> FLAGS=000. RST_N low mid-stream -> RSP_VALID=0 immediately, and after release requester 0 is granted first.
